rgb_stream_packer: RTL and testbench

- Downstream neighbour of the Mandelbrot pixel generator.
- Accepts one 24-bit RGB pixel per handshake and packs the pixel byte stream densely into 32-bit AXI4-Stream words: 4 pixels become 3 words.
- Generates tlast at end of line and tuser at start of frame for the VDMA.
- Applies back-pressure to the generator through in_ready.

---
 rtl/rgb_stream_packer_pkg.sv | 28 ++
 rtl/rgb_stream_packer_if.sv | 30 +++
 rtl/rgb_stream_packer.sv | 178 +++++++++++++++++
 tb/tb_rgb_stream_packer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_stream_packer_pkg.sv
// Shared types and constants for the RGB-to-AXI4-Stream packer:
// packing phases, tkeep patterns and the pixel record.
package rgb_stream_pkg;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    localparam logic [3:0] KEEP_FULL = 4'b1111;
    localparam logic [3:0] KEEP_3B   = 4'b0111;
    localparam logic [3:0] KEEP_2B   = 4'b0011;
    localparam logic [3:0] KEEP_1B   = 4'b0001;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // Returns the pixel's three stream bytes as {byte2, byte1, byte0}.
    function automatic logic [23:0] pixel_bytes(input pixel_t p, input logic bgr);
        return bgr ? {p.r, p.g, p.b} : {p.b, p.g, p.r};
    endfunction

endpackage

// File: rtl/rgb_stream_packer_if.sv
// Pixel-in / AXI4-Stream-out bundle of the packer; master is the packer's view,
// slave is the view of the surrounding generator and sink.
interface rgb_stream_packer_if;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        valid;
    logic        sof;
    logic        eol;
    logic        in_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;
    logic        align_err;

    modport master (
        input  r, g, b, valid, sof, eol, out_stream_tready,
        output in_ready, out_stream_tdata, out_stream_tkeep, out_stream_tlast,
               out_stream_tuser, out_stream_tvalid, align_err
    );

    modport slave (
        output r, g, b, valid, sof, eol, out_stream_tready,
        input  in_ready, out_stream_tdata, out_stream_tkeep, out_stream_tlast,
               out_stream_tuser, out_stream_tvalid, align_err
    );
endinterface

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels densely into 32-bit AXI4-Stream words (4 pixels -> 3 words).
// Define PACKER_PARTIAL_FLUSH_EN to close misaligned lines with short words instead of flagging them.
module rgb_stream_packer
    import rgb_stream_pkg::*;
#(
    parameter int LANE_ORDER = 0
) (
    input  logic                aclk,
    input  logic                areset,
    rgb_stream_packer_if.master bus
);
    // state | meaning
    // PH0   | word aligned, no residual bytes
    // PH1   | one whole pixel (3 bytes) held in res
    // PH2   | 2 bytes held in res[15:0]
    // PH3   | 1 byte held in res[7:0]

    phase_t      phase_q, phase_d, ph_eff;
    logic [23:0] res_q, res_d;
    logic        pend_q, pend_d;
    logic [3:0]  pkeep_q, pkeep_d;
    logic        sof_pend_q, sof_pend_d;
    logic        err_q, err_d;
    logic [31:0] tdata_q, tdata_d;
    logic [3:0]  tkeep_q, tkeep_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic        tvalid_q, tvalid_d;

    pixel_t      pix;
    logic [23:0] px;
    logic        load, accept, tu;

    assign pix = '{r: bus.r, g: bus.g, b: bus.b};
    assign px  = pixel_bytes(pix, LANE_ORDER != 0);

    always_ff @(posedge aclk) begin
        if (areset) begin
            phase_q    <= PH0;
            res_q      <= '0;
            pend_q     <= 1'b0;
            pkeep_q    <= '0;
            sof_pend_q <= 1'b0;
            err_q      <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            tvalid_q   <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            res_q      <= res_d;
            pend_q     <= pend_d;
            pkeep_q    <= pkeep_d;
            sof_pend_q <= sof_pend_d;
            err_q      <= err_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            tvalid_q   <= tvalid_d;
        end
    end

    always_comb begin
        load       = !tvalid_q || bus.out_stream_tready;
        accept     = bus.valid && load && !pend_q;
        // an sof pixel always restarts packing at a word boundary
        ph_eff     = bus.sof ? PH0 : phase_q;
        tu         = bus.sof || sof_pend_q;
        phase_d    = phase_q;
        res_d      = res_q;
        pend_d     = pend_q;
        pkeep_d    = pkeep_q;
        sof_pend_d = sof_pend_q;
        err_d      = err_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        tuser_d    = tuser_q;
        tvalid_d   = tvalid_q && !bus.out_stream_tready;

        if (pend_q && load) begin
            tvalid_d = 1'b1;
            tdata_d  = {8'h00, res_q};
            tkeep_d  = pkeep_q;
            tlast_d  = 1'b1;
            tuser_d  = 1'b0;
            pend_d   = 1'b0;
            res_d    = '0;
        end else if (accept) begin
            if (bus.sof && phase_q != PH0) err_d = 1'b1;
            sof_pend_d = tu;
            unique case (ph_eff)
                PH0: begin
                    res_d   = px;
                    phase_d = PH1;
                    if (bus.eol) begin
`ifdef PACKER_PARTIAL_FLUSH_EN
                        tvalid_d = 1'b1;
                        tdata_d  = {8'h00, px};
                        tkeep_d  = KEEP_3B;
                        tlast_d  = 1'b1;
                        tuser_d  = tu;
`else
                        err_d    = 1'b1;
`endif
                        sof_pend_d = 1'b0;
                        res_d      = '0;
                        phase_d    = PH0;
                    end
                end
                PH1: begin
                    tvalid_d   = 1'b1;
                    tdata_d    = {px[7:0], res_q};
                    tkeep_d    = KEEP_FULL;
                    tlast_d    = 1'b0;
                    tuser_d    = tu;
                    sof_pend_d = 1'b0;
                    res_d      = {8'h00, px[23:8]};
                    phase_d    = PH2;
                    if (bus.eol) begin
                        phase_d = PH0;
`ifdef PACKER_PARTIAL_FLUSH_EN
                        pend_d  = 1'b1;
                        pkeep_d = KEEP_2B;
`else
                        tlast_d = 1'b1;
                        err_d   = 1'b1;
                        res_d   = '0;
`endif
                    end
                end
                PH2: begin
                    tvalid_d   = 1'b1;
                    tdata_d    = {px[15:0], res_q[15:0]};
                    tkeep_d    = KEEP_FULL;
                    tlast_d    = 1'b0;
                    tuser_d    = tu;
                    sof_pend_d = 1'b0;
                    res_d      = {16'h0000, px[23:16]};
                    phase_d    = PH3;
                    if (bus.eol) begin
                        phase_d = PH0;
`ifdef PACKER_PARTIAL_FLUSH_EN
                        pend_d  = 1'b1;
                        pkeep_d = KEEP_1B;
`else
                        tlast_d = 1'b1;
                        err_d   = 1'b1;
                        res_d   = '0;
`endif
                    end
                end
                PH3: begin
                    tvalid_d   = 1'b1;
                    tdata_d    = {px, res_q[7:0]};
                    tkeep_d    = KEEP_FULL;
                    tlast_d    = bus.eol;
                    tuser_d    = tu;
                    sof_pend_d = 1'b0;
                    res_d      = '0;
                    phase_d    = PH0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready          = load && !pend_q;
    assign bus.out_stream_tdata  = tdata_q;
    assign bus.out_stream_tkeep  = tkeep_q;
    assign bus.out_stream_tlast  = tlast_q;
    assign bus.out_stream_tuser  = tuser_q;
    assign bus.out_stream_tvalid = tvalid_q;
    assign bus.align_err         = err_q;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Self-checking bench for rgb_stream_packer: directed cases plus randomized traffic
// compared against a byte-queue reference model of the packed stream.
module tb_rgb_stream_packer;

    logic aclk;
    logic areset;

    rgb_stream_packer_if bus ();

    rgb_stream_packer dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int n_chk = 0;
    int n_err = 0;
    int n_words = 0;
    bit rand_rdy = 0;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       l;
    } mbyte_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } word_t;

    mbyte_t bq[$];
    word_t  exp_q[$];
    logic   m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic pop_word(input int n);
        word_t  w;
        mbyte_t b;
        w.data = '0;
        w.keep = '0;
        w.last = 1'b0;
        w.user = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = bq.pop_front();
            w.data[8*i +: 8] = b.d;
            w.keep[i] = 1'b1;
            w.user |= b.s;
            w.last |= b.l;
        end
        exp_q.push_back(w);
    endtask

    // Reference: the stream is a byte sequence R,G,B per pixel, cut into 4-byte words.
    task automatic model_pixel(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb,
                               input logic ps, input logic pe);
        int n_new = 0;
        if (ps && bq.size() != 0) begin
            bq.delete();
            m_err = 1'b1;
        end
        bq.push_back('{d: pr, s: ps, l: 1'b0});
        bq.push_back('{d: pg, s: 1'b0, l: 1'b0});
        bq.push_back('{d: pb, s: 1'b0, l: pe});
        while (bq.size() >= 4) begin
            pop_word(4);
            n_new++;
        end
        if (pe && bq.size() != 0) begin
`ifdef PACKER_PARTIAL_FLUSH_EN
            pop_word(bq.size());
`else
            if (n_new > 0) exp_q[exp_q.size() - 1].last = 1'b1;
            bq.delete();
            m_err = 1'b1;
`endif
        end
    endtask

    always @(negedge aclk) begin
        if (areset) begin
            exp_q.delete();
            bq.delete();
            m_err = 1'b0;
        end else begin
            if (bus.out_stream_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", bus.out_stream_tdata, 32'hxxxx_xxxx);
                end else if (bus.out_stream_tready) begin
                    check("word_data", bus.out_stream_tdata, exp_q[0].data);
                    check("word_keep", {28'd0, bus.out_stream_tkeep}, {28'd0, exp_q[0].keep});
                    check("word_last", {31'd0, bus.out_stream_tlast}, {31'd0, exp_q[0].last});
                    check("word_user", {31'd0, bus.out_stream_tuser}, {31'd0, exp_q[0].user});
                    void'(exp_q.pop_front());
                    n_words++;
                end else begin
                    check("held_data", bus.out_stream_tdata, exp_q[0].data);
                end
            end
            if (bus.valid && bus.in_ready)
                model_pixel(bus.r, bus.g, bus.b, bus.sof, bus.eol);
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
        if (rand_rdy) bus.out_stream_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        bus.valid = 1'b0;
        bus.sof   = 1'b0;
        bus.eol   = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_pixel(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb,
                              input logic ps, input logic pe);
        int   t = 0;
        logic acc;
        bus.r     = pr;
        bus.g     = pg;
        bus.b     = pb;
        bus.sof   = ps;
        bus.eol   = pe;
        bus.valid = 1'b1;
        forever begin
            @(negedge aclk);
            acc = bus.in_ready;
            step();
            if (acc) break;
            t++;
            if (t > 200) begin
                check("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        bus.valid = 1'b0;
        bus.sof   = 1'b0;
        bus.eol   = 1'b0;
    endtask

    task automatic drain();
        bus.out_stream_tready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    int w0;
    logic s, e;

    initial begin
        areset = 1'b1;
        bus.r = '0; bus.g = '0; bus.b = '0;
        bus.valid = 1'b0; bus.sof = 1'b0; bus.eol = 1'b0;
        bus.out_stream_tready = 1'b1;
        repeat (3) step();
        @(negedge aclk);
        check("rst_tvalid", {31'd0, bus.out_stream_tvalid}, 32'd0);
        check("rst_tdata", bus.out_stream_tdata, 32'd0);
        check("rst_tkeep", {28'd0, bus.out_stream_tkeep}, 32'd0);
        check("rst_tlast", {31'd0, bus.out_stream_tlast}, 32'd0);
        check("rst_tuser", {31'd0, bus.out_stream_tuser}, 32'd0);
        check("rst_align_err", {31'd0, bus.align_err}, 32'd0);
        areset = 1'b0;
        step();

        // four aligned pixels, sof on the first
        w0 = n_words;
        send_pixel(8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
        send_pixel(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
        send_pixel(8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
        send_pixel(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b0);
        idle(4);
        check("t1_words", n_words - w0, 32'd3);

        // full 640-pixel line
        w0 = n_words;
        for (int i = 0; i < 640; i++)
            send_pixel(8'($urandom), 8'($urandom), 8'($urandom), i == 0, i == 639);
        idle(5);
        check("line_words", n_words - w0, 32'd480);
        check("line_align_err", {31'd0, bus.align_err}, 32'd0);

        // back-pressure: hold word 0 for 5 cycles
        w0 = n_words;
        send_pixel(8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
        send_pixel(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
        bus.out_stream_tready = 1'b0;
        bus.r = 8'h07; bus.g = 8'h08; bus.b = 8'h09; bus.valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_tvalid", {31'd0, bus.out_stream_tvalid}, 32'd1);
            step();
        end
        bus.out_stream_tready = 1'b1;
        send_pixel(8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
        send_pixel(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b0);
        idle(4);
        check("stall_words", n_words - w0, 32'd3);

        // two-pixel line ending misaligned
        send_pixel(8'h11, 8'h12, 8'h13, 1'b1, 1'b0);
        send_pixel(8'h14, 8'h15, 8'h16, 1'b0, 1'b1);
        @(negedge aclk);
`ifdef PACKER_PARTIAL_FLUSH_EN
        check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
`else
        check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
`endif
        idle(4);
        check("short_align_err", {31'd0, bus.align_err}, {31'd0, m_err});

        // reset while a word is held at phase 2
        bus.out_stream_tready = 1'b0;
        send_pixel(8'h21, 8'h22, 8'h23, 1'b1, 1'b0);
        send_pixel(8'h24, 8'h25, 8'h26, 1'b0, 1'b0);
        areset = 1'b1;
        step();
        areset = 1'b0;
        @(negedge aclk);
        check("rst_mid_tvalid", {31'd0, bus.out_stream_tvalid}, 32'd0);
        check("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_mid_align_err", {31'd0, bus.align_err}, 32'd0);
        step();
        bus.out_stream_tready = 1'b1;
        w0 = n_words;
        send_pixel(8'h31, 8'h32, 8'h33, 1'b0, 1'b0);
        send_pixel(8'h34, 8'h35, 8'h36, 1'b0, 1'b0);
        send_pixel(8'h37, 8'h38, 8'h39, 1'b0, 1'b0);
        send_pixel(8'h3A, 8'h3B, 8'h3C, 1'b0, 1'b0);
        idle(4);
        check("post_rst_words", n_words - w0, 32'd3);

        // randomized traffic with random back-pressure
        rand_rdy = 1;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 19) == 0);
            send_pixel(8'($urandom), 8'($urandom), 8'($urandom), s, e);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_rdy = 0;
        idle(1);
        drain();
        check("final_align_err", {31'd0, bus.align_err}, {31'd0, m_err});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
